// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard-control bus: the status the pipeline reports to the hazard
// controller and the stall/flush/MDU controls it gets back.
// master = hazard controller, slave = pipeline datapath.
interface pipe_hazard_ctrl_if #(
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int STALL_CNT_WIDTH = 32
);
   // ID/EX operand information for load-use detection
   logic [REG_ADDR_WIDTH-1:0]  id_rs1;
   logic [REG_ADDR_WIDTH-1:0]  id_rs2;
   logic                       id_uses_rs1;
   logic                       id_uses_rs2;
   logic [REG_ADDR_WIDTH-1:0]  ex_rd;
   logic                       ex_mem_read;
   logic                       ex_branch_taken;

   // MDU handshake
   logic                       ex_mdu_op;
   logic                       mdu_done;
   logic                       mdu_start;

   // Memory wait states
   logic                       dmem_req;
   logic                       dmem_ready;
   logic                       imem_ready;

   // Pipeline register controls
   logic                       pc_stall;
   logic                       if_id_stall;
   logic                       id_ex_stall;
   logic                       ex_mem_stall;
   logic                       if_id_flush;
   logic                       id_ex_flush;
   logic                       ex_mem_flush;
   logic                       mem_wb_flush;

   // Status
   logic                       mdu_err;
   logic [STALL_CNT_WIDTH-1:0] stall_cycles;

   modport master (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
             ex_branch_taken, ex_mdu_op, mdu_done, dmem_req, dmem_ready, imem_ready,
      output mdu_start, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
             mdu_err, stall_cycles
   );

   modport slave (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
             ex_branch_taken, ex_mdu_op, mdu_done, dmem_req, dmem_ready, imem_ready,
      input  mdu_start, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
             mdu_err, stall_cycles
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Combines memory wait states, multi-cycle MDU operations, taken branches and
// load-use hazards into per-register stall/flush controls, sequences the MDU
// start/done handshake with a timeout, and counts pc-stall cycles.
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int MDU_TIMEOUT     = 64,
   parameter int STALL_CNT_WIDTH = 32
) (
   input logic                  clk,
   input logic                  rst,
   pipe_hazard_ctrl_if.master   hz_io
);

   // Wait counter only has to reach MDU_TIMEOUT-1.
   localparam int CNT_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MDU_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MDU_WAIT = 2'd1,
      ST_MDU_HOLD = 2'd2
   } state_e;

   state_e                     state_q;
   logic [CNT_W-1:0]           wait_cnt_q;
   logic                       mdu_err_q;
   logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;

   logic mem_wait_s;
   logic in_run_s;
   logic in_wait_s;
   logic in_hold_s;
   logic timeout_s;
   logic mdu_fin_s;
   logic mdu_busy_s;
   logic load_use_s;
   logic rs1_hit_s;
   logic rs2_hit_s;

   logic pc_stall_s;
   logic if_id_stall_s;
   logic id_ex_stall_s;
   logic ex_mem_stall_s;
   logic if_id_flush_s;
   logic id_ex_flush_s;
   logic ex_mem_flush_s;
   logic mem_wb_flush_s;
   logic mdu_start_s;

   // Hazard condition decode shared by output logic and the FSM.
   always_comb begin
      mem_wait_s = hz_io.dmem_req & ~hz_io.dmem_ready;
      in_run_s   = (state_q == ST_RUN);
      in_wait_s  = (state_q == ST_MDU_WAIT);
      in_hold_s  = (state_q == ST_MDU_HOLD);
      // mdu_done only counts while actually waiting for it.
      timeout_s  = in_wait_s & (wait_cnt_q == TIMEOUT_LAST);
      mdu_fin_s  = in_wait_s & (hz_io.mdu_done | timeout_s);
      mdu_busy_s = (in_run_s & hz_io.ex_mdu_op) | (in_wait_s & ~mdu_fin_s);
      rs1_hit_s  = hz_io.id_uses_rs1 & (hz_io.id_rs1 == hz_io.ex_rd);
      rs2_hit_s  = hz_io.id_uses_rs2 & (hz_io.id_rs2 == hz_io.ex_rd);
      load_use_s = hz_io.ex_mem_read
                 & (hz_io.ex_rd != {REG_ADDR_WIDTH{1'b0}})
                 & (rs1_hit_s | rs2_hit_s);
   end

   // Prioritised stall/flush generation; the first matching rule wins.
   always_comb begin
      pc_stall_s     = 1'b0;
      if_id_stall_s  = 1'b0;
      id_ex_stall_s  = 1'b0;
      ex_mem_stall_s = 1'b0;
      if_id_flush_s  = 1'b0;
      id_ex_flush_s  = 1'b0;
      ex_mem_flush_s = 1'b0;
      mem_wb_flush_s = 1'b0;
      mdu_start_s    = 1'b0;
      if (rst) begin
         // Bubble every register while in reset.
         if_id_flush_s  = 1'b1;
         id_ex_flush_s  = 1'b1;
         ex_mem_flush_s = 1'b1;
         mem_wb_flush_s = 1'b1;
      end else if (mem_wait_s) begin
         // Freeze everything up to EX/MEM, bubble into WB.
         pc_stall_s     = 1'b1;
         if_id_stall_s  = 1'b1;
         id_ex_stall_s  = 1'b1;
         ex_mem_stall_s = 1'b1;
         mem_wb_flush_s = 1'b1;
      end else if (mdu_busy_s) begin
         // Hold the MDU op in EX, bubble into MEM.
         pc_stall_s     = 1'b1;
         if_id_stall_s  = 1'b1;
         id_ex_stall_s  = 1'b1;
         ex_mem_flush_s = 1'b1;
         mdu_start_s    = in_run_s;
      end else begin
         // Normal flow, including the MDU exit cycle (ex_mdu_op ignored).
         if (hz_io.ex_branch_taken) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
         end else if (load_use_s) begin
            pc_stall_s    = 1'b1;
            if_id_stall_s = 1'b1;
            id_ex_flush_s = 1'b1;
         end else if (!hz_io.imem_ready) begin
            pc_stall_s    = 1'b1;
            if_id_flush_s = 1'b1;
         end else begin
            pc_stall_s    = 1'b0;
         end
      end
   end

   // MDU sequencing FSM with wait counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= {CNT_W{1'b0}};
         mdu_err_q  <= 1'b0;
      end else begin
         if (timeout_s) begin
            mdu_err_q <= 1'b1;
         end else begin
            mdu_err_q <= mdu_err_q;
         end
         case (state_q)
            ST_RUN: begin
               if (!mem_wait_s && hz_io.ex_mdu_op) begin
                  state_q    <= ST_MDU_WAIT;
                  wait_cnt_q <= {CNT_W{1'b0}};
               end else begin
                  state_q    <= ST_RUN;
               end
            end
            ST_MDU_WAIT: begin
               if (mdu_fin_s) begin
                  state_q <= mem_wait_s ? ST_MDU_HOLD : ST_RUN;
               end else begin
                  // Cannot wrap: the timeout fires at TIMEOUT_LAST.
                  wait_cnt_q <= wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_MDU_HOLD: begin
               if (!mem_wait_s) begin
                  state_q <= ST_RUN;
               end else begin
                  state_q <= ST_MDU_HOLD;
               end
            end
            default: begin
               state_q    <= ST_RUN;
               wait_cnt_q <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Saturating count of cycles with the PC held.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= {STALL_CNT_WIDTH{1'b0}};
      end else if (pc_stall_s && !(&stall_cnt_q)) begin
         stall_cnt_q <= stall_cnt_q + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_q <= stall_cnt_q;
      end
   end

   assign hz_io.pc_stall     = pc_stall_s;
   assign hz_io.if_id_stall  = if_id_stall_s;
   assign hz_io.id_ex_stall  = id_ex_stall_s;
   assign hz_io.ex_mem_stall = ex_mem_stall_s;
   assign hz_io.if_id_flush  = if_id_flush_s;
   assign hz_io.id_ex_flush  = id_ex_flush_s;
   assign hz_io.ex_mem_flush = ex_mem_flush_s;
   assign hz_io.mem_wb_flush = mem_wb_flush_s;
   assign hz_io.mdu_start    = mdu_start_s;
   assign hz_io.mdu_err      = mdu_err_q;
   assign hz_io.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a cycle-age based reference model.
// A second instance with a 4-bit stall counter exercises saturation.
module tb_pipe_hazard_ctrl;

   localparam int RW  = 5;
   localparam int TO  = 8;

   logic clk = 1'b0;
   logic rst;
   logic [RW-1:0] id_rs1, id_rs2, ex_rd;
   logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
   logic ex_mdu_op, mdu_done, dmem_req, dmem_ready, imem_ready;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.REG_ADDR_WIDTH(RW), .STALL_CNT_WIDTH(32)) hz_a ();
   pipe_hazard_ctrl_if #(.REG_ADDR_WIDTH(RW), .STALL_CNT_WIDTH(4))  hz_b ();

   pipe_hazard_ctrl #(.REG_ADDR_WIDTH(RW), .MDU_TIMEOUT(TO), .STALL_CNT_WIDTH(32)) u_dut (
      .clk(clk), .rst(rst), .hz_io(hz_a));
   pipe_hazard_ctrl #(.REG_ADDR_WIDTH(RW), .MDU_TIMEOUT(TO), .STALL_CNT_WIDTH(4)) u_dut_sat (
      .clk(clk), .rst(rst), .hz_io(hz_b));

   assign hz_a.id_rs1 = id_rs1;           assign hz_b.id_rs1 = id_rs1;
   assign hz_a.id_rs2 = id_rs2;           assign hz_b.id_rs2 = id_rs2;
   assign hz_a.id_uses_rs1 = id_uses_rs1; assign hz_b.id_uses_rs1 = id_uses_rs1;
   assign hz_a.id_uses_rs2 = id_uses_rs2; assign hz_b.id_uses_rs2 = id_uses_rs2;
   assign hz_a.ex_rd = ex_rd;             assign hz_b.ex_rd = ex_rd;
   assign hz_a.ex_mem_read = ex_mem_read; assign hz_b.ex_mem_read = ex_mem_read;
   assign hz_a.ex_branch_taken = ex_branch_taken; assign hz_b.ex_branch_taken = ex_branch_taken;
   assign hz_a.ex_mdu_op = ex_mdu_op;     assign hz_b.ex_mdu_op = ex_mdu_op;
   assign hz_a.mdu_done = mdu_done;       assign hz_b.mdu_done = mdu_done;
   assign hz_a.dmem_req = dmem_req;       assign hz_b.dmem_req = dmem_req;
   assign hz_a.dmem_ready = dmem_ready;   assign hz_b.dmem_ready = dmem_ready;
   assign hz_a.imem_ready = imem_ready;   assign hz_b.imem_ready = imem_ready;

   // {pc, if_id, id_ex, ex_mem stall, if_id, id_ex, ex_mem, mem_wb flush, mdu_start}
   wire [8:0] got_ctl = {hz_a.pc_stall, hz_a.if_id_stall, hz_a.id_ex_stall, hz_a.ex_mem_stall,
                         hz_a.if_id_flush, hz_a.id_ex_flush, hz_a.ex_mem_flush, hz_a.mem_wb_flush,
                         hz_a.mdu_start};

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: tracks whether an MDU op is outstanding and how many
   // cycles have passed since its start cycle (exit due at age TO).
   bit      m_waiting;   // start issued, result not yet accepted
   bit      m_parked;    // result accepted, waiting for memory to release
   int      m_age;       // cycles since the start cycle
   bit      m_err;
   longint  m_stalls;
   logic [8:0] exp_ctl;
   bit      e_memwait, e_fin;

   function automatic longint sat(input longint v, input int w);
      longint mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      m_waiting = 0; m_parked = 0; m_age = 0; m_err = 0; m_stalls = 0;
   endtask

   task automatic model_eval();
      bit lu;
      e_memwait = dmem_req && !dmem_ready;
      e_fin     = m_waiting && (mdu_done || m_age == TO);
      lu = ex_mem_read && ex_rd != 0 &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      if (rst)                                         exp_ctl = 9'b0000_1111_0;
      else if (e_memwait)                              exp_ctl = 9'b1111_0001_0;
      else if (!m_waiting && !m_parked && ex_mdu_op)   exp_ctl = 9'b1110_0010_1;
      else if (m_waiting && !e_fin)                    exp_ctl = 9'b1110_0010_0;
      else if (ex_branch_taken)                        exp_ctl = 9'b0000_1100_0;
      else if (lu)                                     exp_ctl = 9'b1100_0100_0;
      else if (!imem_ready)                            exp_ctl = 9'b1000_1000_0;
      else                                             exp_ctl = 9'b0000_0000_0;
   endtask

   task automatic model_clock();
      if (rst) begin
         model_reset();
      end else begin
         if (exp_ctl[8]) m_stalls = sat(m_stalls + 1, 32);
         if (m_waiting && m_age == TO) m_err = 1;
         if (e_fin) begin
            m_waiting = 0;
            m_parked  = e_memwait;
         end else if (m_waiting) begin
            m_age++;
         end else if (m_parked) begin
            m_parked = e_memwait;
         end else if (exp_ctl[0]) begin
            m_waiting = 1;
            m_age     = 1;
         end
      end
   endtask

   // One checked cycle: inputs are already driven at posedge+1.
   task automatic step(input string tag);
      model_eval();
      @(negedge clk);
      check_eq({tag, "/ctl"}, 64'(got_ctl), 64'(exp_ctl));
      check_eq({tag, "/err"}, 64'(hz_a.mdu_err), 64'(m_err));
      check_eq({tag, "/cnt"}, 64'(hz_a.stall_cycles), 64'(m_stalls));
      check_eq({tag, "/sat"}, 64'(hz_b.stall_cycles), 64'(sat(m_stalls, 4)));
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_rd = '0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_mdu_op = 1'b0;
      mdu_done = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      step("rst");
      idle(); step("idle");

      // Load x5 then consumer of x5: one bubble, then free flow.
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; step("lu");
      check_eq("lu_bubble_cnt", 64'(hz_a.stall_cycles), 64'd1);
      idle(); step("lu_next");
      // Load to x0 never stalls.
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1; step("lu_x0");
      // Branch wins over load-use.
      ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; ex_branch_taken = 1'b1; step("br_lu");
      idle();

      // MDU with done 5 cycles after start.
      ex_mdu_op = 1'b1; step("mdu_start");
      for (int k = 1; k < 5; k++) step("mdu_busy");
      mdu_done = 1'b1; step("mdu_done");
      mdu_done = 1'b0; ex_mdu_op = 1'b0; step("mdu_after");
      check_eq("err_clear", 64'(hz_a.mdu_err), 64'd0);

      // MDU with no done: exit at start+TO, sticky error.
      ex_mdu_op = 1'b1; step("to_start");
      for (int k = 1; k <= TO; k++) step("to_wait");
      ex_mdu_op = 1'b0; step("to_after");
      check_eq("err_set", 64'(hz_a.mdu_err), 64'd1);

      // Done while data memory stalls for 3 cycles.
      ex_mdu_op = 1'b1; step("hold_start");
      step("hold_wait");
      dmem_req = 1'b1; dmem_ready = 1'b0; mdu_done = 1'b1; step("hold_done");
      mdu_done = 1'b0; step("hold_mw1"); step("hold_mw2");
      dmem_ready = 1'b1; step("hold_exit");
      idle(); step("hold_after");

      // imem wait: counter tracks pc stalls; small counter saturates.
      imem_ready = 1'b0;
      for (int k = 0; k < 20; k++) step("imem");
      check_eq("sat_full", 64'(hz_b.stall_cycles), 64'hF);
      idle(); rst = 1'b1; step("rst2");
      check_eq("rst_cnt", 64'(hz_a.stall_cycles), 64'd0);
      check_eq("rst_err", 64'(hz_a.mdu_err), 64'd0);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rst             = ($urandom_range(0, 199) == 0);
         id_rs1          = RW'($urandom_range(0, 3));
         id_rs2          = RW'($urandom_range(0, 3));
         ex_rd           = RW'($urandom_range(0, 3));
         id_uses_rs1     = $urandom_range(0, 1) == 1;
         id_uses_rs2     = $urandom_range(0, 1) == 1;
         ex_mem_read     = $urandom_range(0, 2) == 0;
         ex_branch_taken = $urandom_range(0, 7) == 0;
         ex_mdu_op       = $urandom_range(0, 5) == 0;
         mdu_done        = $urandom_range(0, 5) == 0;
         dmem_req        = $urandom_range(0, 2) == 0;
         dmem_ready      = $urandom_range(0, 1) == 1;
         imem_ready      = $urandom_range(0, 3) != 0;
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
